// File: rtl/gpr_file_mp.sv
// Multi-ported GPR file for the ID stage: NUM_RD combinational reads, two write ports
// (WB1 wins on collision), optional write-before-read bypass, hardwired R0 and busy scoreboard.
module gpr_file_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     alloc_valid,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (we0 && (waddr0 == ADDR_W'(i))) regs_d[i] = wdata0;
      if (we1 && (waddr1 == ADDR_W'(i))) regs_d[i] = wdata1;
    end
    if (ZERO_R0 != 0) regs_d[0] = '0;
  end

  // A same-cycle allocation is younger than any flush or completing write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i] = busy_q[i];
      if (alloc_valid && (alloc_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (flush) begin
        busy_d[i] = 1'b0;
      end else if ((we0 && (waddr0 == ADDR_W'(i))) || (we1 && (waddr1 == ADDR_W'(i)))) begin
        busy_d[i] = 1'b0;
      end
    end
    if (ZERO_R0 != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] idx;
    logic              hit0;
    logic              hit1;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      idx  = rd_addr[k*ADDR_W +: ADDR_W];
      hit0 = we0 && (waddr0 == idx);
      hit1 = we1 && (waddr1 == idx);
      rd_data[k*DATA_W +: DATA_W] = regs_q[idx];
      rd_busy[k]                  = busy_q[idx];
      if (BYPASS != 0) begin
        if (hit1) begin
          rd_data[k*DATA_W +: DATA_W] = wdata1;
        end else if (hit0) begin
          rd_data[k*DATA_W +: DATA_W] = wdata0;
        end
        if (hit0 || hit1) rd_busy[k] = 1'b0;
      end
      if ((ZERO_R0 != 0) && (idx == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end
    end
    // Held in reset, nothing (not even a bypassed write) is visible.
    if (!reset) begin
      rd_data = '0;
      rd_busy = '0;
    end
  end

endmodule
